// File: rtl/instr_fetch_unit.sv
// In-order instruction fetch with a DEPTH-entry PC/word queue; optional misaligned-redirect trap under FETCH_MISALIGN_TRAP_EN.
// Word reaches decode at least 2 cycles after its request; issue stops when allocated + squashed entries reach DEPTH.
module instr_fetch_unit #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] pc,
   output logic [31:0] next_pc,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   output logic        if_valid,
   input  logic        if_ready,
   output logic [31:0] if_instr,
   output logic [31:0] if_pc,
   output logic        if_misalign
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic {ST_RUN, ST_HALT} state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   count_q, count_d;
   logic [CW-1:0]   drop_q, drop_d;
   logic [CW-1:0]   pend_q, pend_d;
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]   fill_ptr_q, fill_ptr_d;
   logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [31:0]     ent_pc_q     [DEPTH];
   logic [31:0]     ent_pc_d     [DEPTH];
   logic [31:0]     ent_instr_q  [DEPTH];
   logic [31:0]     ent_instr_d  [DEPTH];
   logic            ent_filled_q [DEPTH];
   logic            ent_filled_d [DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
   logic            ent_mis_q    [DEPTH];
   logic            ent_mis_d    [DEPTH];
`endif

   logic            fire;
   logic            pop;
   logic            live_rsp;
   logic [CW:0]     occupancy;

   always_comb begin
      state_d    = state_q;
      count_d    = count_q;
      drop_d     = drop_q;
      pend_d     = pend_q;
      wr_ptr_d   = wr_ptr_q;
      fill_ptr_d = fill_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      for (int i = 0; i < DEPTH; i++) begin
         ent_pc_d[i]     = ent_pc_q[i];
         ent_instr_d[i]  = ent_instr_q[i];
         ent_filled_d[i] = ent_filled_q[i];
`ifdef FETCH_MISALIGN_TRAP_EN
         ent_mis_d[i]    = ent_mis_q[i];
`endif
      end

      occupancy      = {1'b0, count_q} + {1'b0, drop_q};
      imem_req_valid = rst_n && (state_q == ST_RUN) && !redirect
                       && (occupancy < (CW+1)'(DEPTH));
      imem_req_addr  = {pc[31:2], 2'b00};
      fire           = imem_req_valid && imem_req_ready;

      if_valid    = rst_n && ent_filled_q[rd_ptr_q] && !redirect && (count_q != '0);
      if_instr    = ent_instr_q[rd_ptr_q];
      if_pc       = ent_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
      if_misalign = if_valid && ent_mis_q[rd_ptr_q];
`else
      if_misalign = 1'b0;
`endif
      pop         = if_valid && if_ready;

      // A response belongs to the queue only once all squashed words have drained.
      live_rsp = imem_rsp_valid && (drop_q == '0) && (pend_q != '0);

      if (!rst_n) begin
         next_pc = 32'h0;
      end else if (redirect) begin
         next_pc = redirect_pc;
      end else if (fire) begin
         next_pc = pc + 32'd4;
      end else begin
         next_pc = pc;
      end

      if (redirect) begin
         for (int i = 0; i < DEPTH; i++) begin
            ent_filled_d[i] = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            ent_mis_d[i]    = 1'b0;
`endif
         end
         count_d    = '0;
         pend_d     = '0;
         wr_ptr_d   = '0;
         fill_ptr_d = '0;
         rd_ptr_d   = '0;
         state_d    = ST_RUN;
         // The response landing this cycle retires one outstanding word (squashed or pending) on the spot.
         drop_d = drop_q + pend_q
                  - CW'(imem_rsp_valid && ((drop_q != '0) || (pend_q != '0)));
`ifdef FETCH_MISALIGN_TRAP_EN
         if (redirect_pc[1:0] != 2'b00) begin
            ent_pc_d[0]     = redirect_pc;
            ent_instr_d[0]  = 32'h0000_0013;
            ent_filled_d[0] = 1'b1;
            ent_mis_d[0]    = 1'b1;
            count_d         = CW'(1);
            wr_ptr_d        = AW'(1);
            fill_ptr_d      = AW'(1);
            state_d         = ST_HALT;
         end
`endif
      end else begin
         if (imem_rsp_valid && (drop_q != '0)) begin
            drop_d = drop_q - CW'(1);
         end
         if (live_rsp) begin
            ent_instr_d[fill_ptr_q]  = imem_rsp_data;
            ent_filled_d[fill_ptr_q] = 1'b1;
            fill_ptr_d               = fill_ptr_q + AW'(1);
         end
         if (fire) begin
            ent_pc_d[wr_ptr_q]     = pc;
            ent_filled_d[wr_ptr_q] = 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            ent_mis_d[wr_ptr_q]    = 1'b0;
`endif
            wr_ptr_d               = wr_ptr_q + AW'(1);
         end
         if (pop) begin
            ent_filled_d[rd_ptr_q] = 1'b0;
            rd_ptr_d               = rd_ptr_q + AW'(1);
         end
         count_d = count_q + CW'(fire) - CW'(pop);
         pend_d  = pend_q + CW'(fire) - CW'(live_rsp);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= ST_RUN;
         count_q    <= '0;
         drop_q     <= '0;
         pend_q     <= '0;
         wr_ptr_q   <= '0;
         fill_ptr_q <= '0;
         rd_ptr_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc_q[i]     <= '0;
            ent_instr_q[i]  <= '0;
            ent_filled_q[i] <= 1'b0;
`ifdef FETCH_MISALIGN_TRAP_EN
            ent_mis_q[i]    <= 1'b0;
`endif
         end
      end else begin
         state_q    <= state_d;
         count_q    <= count_d;
         drop_q     <= drop_d;
         pend_q     <= pend_d;
         wr_ptr_q   <= wr_ptr_d;
         fill_ptr_q <= fill_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         for (int i = 0; i < DEPTH; i++) begin
            ent_pc_q[i]     <= ent_pc_d[i];
            ent_instr_q[i]  <= ent_instr_d[i];
            ent_filled_q[i] <= ent_filled_d[i];
`ifdef FETCH_MISALIGN_TRAP_EN
            ent_mis_q[i]    <= ent_mis_d[i];
`endif
         end
      end
   end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: vector table for streaming/stall, hand sequences for redirect, wrap and reset.
// Memory model returns ~addr one or more cycles after accept; the bench plays the PC register.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] pc;
   logic [31:0] next_pc;
   logic        redirect;
   logic [31:0] redirect_pc;
   logic        imem_req_valid;
   logic        imem_req_ready;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid;
   logic [31:0] imem_rsp_data;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic        if_misalign;

   always #5 clk = ~clk;

   instr_fetch_unit #(.DEPTH(4)) dut (
      .clk(clk), .rst_n(rst_n), .pc(pc), .next_pc(next_pc),
      .redirect(redirect), .redirect_pc(redirect_pc),
      .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
      .imem_req_addr(imem_req_addr), .imem_rsp_valid(imem_rsp_valid),
      .imem_rsp_data(imem_rsp_data), .if_valid(if_valid), .if_ready(if_ready),
      .if_instr(if_instr), .if_pc(if_pc), .if_misalign(if_misalign)
   );

   int checks = 0;
   int errors = 0;

   logic [31:0] mq[$];
   logic        rsp_en;

   typedef struct {
      logic        rst_n;
      logic        if_rdy;
      logic        exp_req;
      logic        exp_ifv;
      logic [31:0] exp_ifpc;
      logic [31:0] exp_npc;
   } vec_t;

   vec_t tbl[16];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic drive_rsp();
      imem_rsp_valid = rsp_en && (mq.size() > 0);
      imem_rsp_data  = imem_rsp_valid ? ~mq[0] : 32'h0;
   endtask

   task automatic settle();
      drive_rsp();
      #1;
   endtask

   task automatic tick();
      logic        f, c, r;
      logic [31:0] a, n;
      f = imem_req_valid & imem_req_ready;
      a = imem_req_addr;
      c = imem_rsp_valid;
      n = next_pc;
      r = rst_n;
      @(posedge clk);
      #1;
      pc = n;
      if (!r) begin
         mq.delete();
      end else begin
         if (c) void'(mq.pop_front());
         if (f) mq.push_back(a);
      end
      drive_rsp();
   endtask

   task automatic do_reset();
      rst_n = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; rsp_en = 1'b1; if_ready = 1'b1;
      settle(); tick();
      settle(); tick();
      rst_n = 1'b1;
   endtask

   // Waits for the first delivered instruction and checks its PC and word.
   task automatic first_delivery(input string name, input logic [31:0] exp_pc, input logic [31:0] exp_instr);
      logic got;
      got = 1'b0;
      for (int i = 0; i < 20 && !got; i++) begin
         settle();
         if (if_valid) begin
            got = 1'b1;
            chk({name, "_pc"}, if_pc, exp_pc);
            chk({name, "_instr"}, if_instr, exp_instr);
         end
         tick();
      end
      if (!got) begin
         checks++; errors++;
         $display("FAIL %s_timeout actual=no_if_valid required=if_valid_within_20", name);
      end
   endtask

   function automatic vec_t mk(logic r, logic ir, logic rq, logic iv, logic [31:0] ipc, logic [31:0] npc);
      vec_t v;
      v.rst_n = r; v.if_rdy = ir; v.exp_req = rq; v.exp_ifv = iv; v.exp_ifpc = ipc; v.exp_npc = npc;
      return v;
   endfunction

   initial begin : watchdog
      #100000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = mk(0, 1, 0, 0, 32'h0,  32'h0);
      tbl[1]  = mk(0, 1, 0, 0, 32'h0,  32'h0);
      tbl[2]  = mk(1, 1, 1, 0, 32'h0,  32'h4);
      tbl[3]  = mk(1, 1, 1, 0, 32'h0,  32'h8);
      tbl[4]  = mk(1, 1, 1, 1, 32'h0,  32'hC);
      tbl[5]  = mk(1, 1, 1, 1, 32'h4,  32'h10);
      tbl[6]  = mk(1, 1, 1, 1, 32'h8,  32'h14);
      tbl[7]  = mk(1, 1, 1, 1, 32'hC,  32'h18);
      tbl[8]  = mk(1, 0, 1, 1, 32'h10, 32'h1C);
      tbl[9]  = mk(1, 0, 1, 1, 32'h10, 32'h20);
      tbl[10] = mk(1, 0, 0, 1, 32'h10, 32'h20);
      tbl[11] = mk(1, 0, 0, 1, 32'h10, 32'h20);
      tbl[12] = mk(1, 1, 0, 1, 32'h10, 32'h20);
      tbl[13] = mk(1, 1, 1, 1, 32'h14, 32'h24);
      tbl[14] = mk(1, 1, 1, 1, 32'h18, 32'h28);
      tbl[15] = mk(1, 1, 1, 1, 32'h1C, 32'h2C);

      pc = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
      imem_req_ready = 1'b1; rsp_en = 1'b1; if_ready = 1'b1; rst_n = 1'b0;

      for (int i = 0; i < 16; i++) begin
         rst_n    = tbl[i].rst_n;
         if_ready = tbl[i].if_rdy;
         settle();
         chk($sformatf("v%0d_req_valid", i), 32'(imem_req_valid), 32'(tbl[i].exp_req));
         chk($sformatf("v%0d_if_valid", i), 32'(if_valid), 32'(tbl[i].exp_ifv));
         chk($sformatf("v%0d_next_pc", i), next_pc, tbl[i].exp_npc);
         if (tbl[i].exp_ifv) begin
            chk($sformatf("v%0d_if_pc", i), if_pc, tbl[i].exp_ifpc);
            chk($sformatf("v%0d_if_instr", i), if_instr, ~tbl[i].exp_ifpc);
         end
         tick();
      end

      // Decode stalled from an empty queue: exactly DEPTH requests, then pc holds.
      do_reset();
      if_ready = 1'b0;
      begin
         int nfire;
         nfire = 0;
         for (int i = 0; i < 10; i++) begin
            settle();
            if (imem_req_valid && imem_req_ready) nfire++;
            tick();
         end
         settle();
         chk("stall_req_count", 32'(nfire), 32'd4);
         chk("stall_req_valid", 32'(imem_req_valid), 32'd0);
         chk("stall_next_pc_held", next_pc, 32'h10);
         chk("stall_if_pc", if_pc, 32'h0);
      end

      // Three requests in flight when a redirect lands: all three responses squashed.
      do_reset();
      rsp_en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         settle(); tick();
      end
      redirect = 1'b1; redirect_pc = 32'h100;
      settle();
      chk("redir_req_valid", 32'(imem_req_valid), 32'd0);
      chk("redir_if_valid", 32'(if_valid), 32'd0);
      chk("redir_next_pc", next_pc, 32'h100);
      tick();
      redirect = 1'b0; rsp_en = 1'b1;
      first_delivery("redir_first", 32'h100, ~32'h100);

      // Redirect coinciding with a response and an accepting decode.
      do_reset();
      settle(); tick();
      settle(); tick();
      redirect = 1'b1; redirect_pc = 32'h200;
      settle();
      chk("redir_rsp_if_valid", 32'(if_valid), 32'd0);
      tick();
      redirect = 1'b0;
      first_delivery("redir_rsp_first", 32'h200, ~32'h200);

      // Address wrap, then a misaligned redirect target.
      do_reset();
      pc = 32'hFFFF_FFFC;
      settle();
      chk("wrap_req_valid", 32'(imem_req_valid), 32'd1);
      chk("wrap_req_addr", imem_req_addr, 32'hFFFF_FFFC);
      chk("wrap_next_pc", next_pc, 32'h0);
      tick();
      redirect = 1'b1; redirect_pc = 32'h102;
      settle();
      chk("mis_next_pc", next_pc, 32'h102);
      tick();
      redirect = 1'b0;
      settle();
`ifdef FETCH_MISALIGN_TRAP_EN
      chk("mis_req_valid", 32'(imem_req_valid), 32'd0);
      chk("mis_if_valid", 32'(if_valid), 32'd1);
      chk("mis_if_misalign", 32'(if_misalign), 32'd1);
      chk("mis_if_pc", if_pc, 32'h102);
      chk("mis_if_instr", if_instr, 32'h0000_0013);
      tick();
      settle();
      chk("halt_if_valid", 32'(if_valid), 32'd0);
      chk("halt_req_valid", 32'(imem_req_valid), 32'd0);
      tick();
`else
      chk("mis_req_addr", imem_req_addr, 32'h100);
      chk("mis_req_valid", 32'(imem_req_valid), 32'd1);
      chk("mis_if_misalign", 32'(if_misalign), 32'd0);
      first_delivery("mis_first", 32'h102, ~32'h100);
`endif

      // Reset asserted mid-stream.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         settle(); tick();
      end
      rst_n = 1'b0;
      settle();
      chk("rst_comb_if_valid", 32'(if_valid), 32'd0);
      chk("rst_comb_req_valid", 32'(imem_req_valid), 32'd0);
      chk("rst_comb_next_pc", next_pc, 32'h0);
      tick();
      settle();
      chk("rst_next_if_valid", 32'(if_valid), 32'd0);
      chk("rst_next_req_valid", 32'(imem_req_valid), 32'd0);
      rst_n = 1'b1;
      settle();
      chk("rst_release_req_valid", 32'(imem_req_valid), 32'd1);
      chk("rst_release_if_valid", 32'(if_valid), 32'd0);
      chk("rst_release_next_pc", next_pc, 32'h4);
      tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
